frame_buf_ctrl: RTL

//  Admission/flow controller between the 6->24 pixel FIFO output and the 256kB USB

---
 rtl/frame_buf_pkg.sv | 20 ++
 rtl/fifo_occ_tracker.sv | 53 +++++
 rtl/frame_buf_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_buf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : frame_buf_pkg                                                  |
// | Shared types and constants for the frame buffer admission controller.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package frame_buf_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DROP     = 2'd3
  } state_e;

  localparam logic [7:0] TRAILER_TAG    = 8'hA5;
  localparam int         FRAMES_AVAIL_W = 4;

endpackage
`default_nettype wire

// File: rtl/fifo_occ_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fifo_occ_tracker                                               |
// | Tracks output FIFO occupancy and answers "does a frame of need_i words   |
// | fit in the free space right now".                                        |
// | Ports   : clk, rst (async, active-high)                                  |
// |           wr_i    word written into the output FIFO                      |
// |           rd_i    word read by host (already qualified as non-empty)     |
// |           need_i  words required by the candidate frame                  |
// |           empty_o occupancy is zero                                      |
// |           fits_o  free space >= need_i                                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fifo_occ_tracker
  import frame_buf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 16,
  parameter int NEED_W     = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i,
  input  logic              rd_i,
  input  logic [NEED_W-1:0] need_i,
  output logic              empty_o,
  output logic              fits_o
);

  // Compare width wide enough for both the need value and the depth.
  localparam int CMP_W = ((NEED_W > DEPTH_LOG2 + 1) ? NEED_W : DEPTH_LOG2 + 1) + 1;
  localparam logic [CMP_W-1:0]    DEPTH_C = {{(CMP_W-1){1'b0}}, 1'b1} << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] OCC_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [DEPTH_LOG2:0] occ_q, occ_d;
  logic [CMP_W-1:0]    free_w;

  always_comb begin
    occ_d = occ_q;
    if (wr_i && !rd_i)      occ_d = occ_q + OCC_ONE;
    else if (rd_i && !wr_i) occ_d = occ_q - OCC_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign free_w  = DEPTH_C - {{(CMP_W-DEPTH_LOG2-1){1'b0}}, occ_q};
  assign fits_o  = free_w >= {{(CMP_W-NEED_W){1'b0}}, need_i};
  assign empty_o = (occ_q == '0);

endmodule
`default_nettype wire

// File: rtl/frame_buf_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : frame_buf_ctrl                                                 |
// | Whole-frame admission controller between the pixel FIFO and the host     |
// | output FIFO. Frames are written whole or dropped whole depending on free |
// | space; completed frames are counted until the host reads them out, and   |
// | stall_o is raised once STALL_FRAMES frames are waiting.                  |
// | Ports   : clk, rst (async, active-high), enable_i, words_per_frame_i,    |
// |           in_valid_i/in_sof_i/in_data_i (input stream),                  |
// |           fifo_wr_en_o/fifo_din_o (output FIFO write), host_rd_i,        |
// |           frames_avail_o, stall_o, frame_done_o, frame_dropped_o,        |
// |           err_sticky_o, frame_cnt_o                                      |
// | Macro   : FRAME_TRAILER_EN adds a {A5,frame_cnt} trailer word per frame  |
// |           plus a 1-deep skid register for the word colliding with it.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module frame_buf_ctrl
  import frame_buf_pkg::*;
#(
  parameter int DATA_W       = 24,
  parameter int DEPTH_LOG2   = 16,
  parameter int CNT_W        = 20,
  parameter int STALL_FRAMES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable_i,
  input  logic [CNT_W-1:0]          words_per_frame_i,
  input  logic                      in_valid_i,
  input  logic                      in_sof_i,
  input  logic [DATA_W-1:0]         in_data_i,
  output logic                      fifo_wr_en_o,
  output logic [DATA_W-1:0]         fifo_din_o,
  input  logic                      host_rd_i,
  output logic [FRAMES_AVAIL_W-1:0] frames_avail_o,
  output logic                      stall_o,
  output logic                      frame_done_o,
  output logic                      frame_dropped_o,
  output logic                      err_sticky_o,
  output logic [15:0]               frame_cnt_o
);

  localparam int               NEED_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NEED_W-1:0] NEED_ONE = {{(NEED_W-1){1'b0}}, 1'b1};

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, wpf_q, wpf_d;
  logic [NEED_W-1:0]         need_q, need_d, rd_cnt_q, rd_cnt_d;
  logic [FRAMES_AVAIL_W-1:0] avail_q, avail_d;
  logic [15:0]               fcnt_q, fcnt_d;
  logic                      stall_q, err_q, err_d;

  logic [CNT_W-1:0]  wpf_eff;
  logic [NEED_W-1:0] need_in;
  logic              proc_vld, proc_sof;
  logic [DATA_W-1:0] proc_data;
  logic              wr_data, last_data, drop, abandon, fcnt_inc, start;
  logic              frame_complete, lost_word, fits, empty, rd_eff, dec;

  assign wpf_eff = (words_per_frame_i == '0) ? CNT_ONE : words_per_frame_i;

`ifdef FRAME_TRAILER_EN
  // A word arriving while the trailer is written is parked in the skid
  // register; while the skid is occupied the stream runs one cycle delayed.
  logic              trl_q;
  logic              skid_vld_q, skid_vld_d, skid_sof_q, skid_sof_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  assign need_in = {1'b0, wpf_eff} + NEED_ONE;

  always_comb begin
    proc_vld    = 1'b0;
    proc_sof    = 1'b0;
    proc_data   = in_data_i;
    skid_vld_d  = 1'b0;
    skid_sof_d  = skid_sof_q;
    skid_data_d = skid_data_q;
    lost_word   = 1'b0;
    if (trl_q) begin
      skid_vld_d = skid_vld_q | in_valid_i;
      if (in_valid_i && skid_vld_q) begin
        lost_word = 1'b1;
      end else if (in_valid_i) begin
        skid_sof_d  = in_sof_i;
        skid_data_d = in_data_i;
      end
    end else if (skid_vld_q) begin
      proc_vld    = 1'b1;
      proc_sof    = skid_sof_q;
      proc_data   = skid_data_q;
      skid_vld_d  = in_valid_i;
      skid_sof_d  = in_sof_i;
      skid_data_d = in_data_i;
    end else begin
      proc_vld = in_valid_i;
      proc_sof = in_sof_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trl_q       <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_sof_q  <= 1'b0;
      skid_data_q <= '0;
    end else begin
      trl_q       <= last_data;
      skid_vld_q  <= skid_vld_d;
      skid_sof_q  <= skid_sof_d;
      skid_data_q <= skid_data_d;
    end
  end

  // The frame counts as complete when its trailer lands in the FIFO.
  assign frame_complete = trl_q;
  assign fifo_wr_en_o   = wr_data | trl_q;
  assign fifo_din_o     = trl_q   ? DATA_W'({TRAILER_TAG, fcnt_q}) :
                          wr_data ? proc_data : '0;
`else
  assign need_in        = {1'b0, wpf_eff};
  assign proc_vld       = in_valid_i;
  assign proc_sof       = in_sof_i;
  assign proc_data      = in_data_i;
  assign lost_word      = 1'b0;
  assign frame_complete = last_data;
  assign fifo_wr_en_o   = wr_data;
  assign fifo_din_o     = wr_data ? proc_data : '0;
`endif

  fifo_occ_tracker #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .NEED_W     (NEED_W)
  ) u_occ (
    .clk     (clk),
    .rst     (rst),
    .wr_i    (fifo_wr_en_o),
    .rd_i    (rd_eff),
    .need_i  (need_in),
    .empty_o (empty),
    .fits_o  (fits)
  );

  // Frame FSM. A start-of-frame seen mid-frame abandons the current frame
  // and is then judged for admission like any other first word.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wpf_d     = wpf_q;
    need_d    = need_q;
    wr_data   = 1'b0;
    last_data = 1'b0;
    drop      = 1'b0;
    abandon   = 1'b0;
    fcnt_inc  = 1'b0;
    start     = 1'b0;
    case (state_q)
      IDLE: if (enable_i) state_d = WAIT_SOF;
      WAIT_SOF: begin
        if (!enable_i)                state_d = IDLE;
        else if (proc_vld && proc_sof) start   = 1'b1;
      end
      CAPTURE: if (proc_vld) begin
        if (proc_sof) begin
          abandon = 1'b1;
          start   = 1'b1;
        end else begin
          wr_data = 1'b1;
          cnt_d   = cnt_q + CNT_ONE;
          if (cnt_q + CNT_ONE == wpf_q) begin
            last_data = 1'b1;
            state_d   = WAIT_SOF;
          end
        end
      end
      DROP: if (proc_vld) begin
        if (proc_sof) begin
          abandon = 1'b1;
          start   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q + CNT_ONE == wpf_q) state_d = WAIT_SOF;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      cnt_d = CNT_ONE;
      wpf_d = wpf_eff;
      if (fits) begin
        wr_data  = 1'b1;
        need_d   = need_in;
        fcnt_inc = 1'b1;
        if (wpf_eff == CNT_ONE) begin
          last_data = 1'b1;
          state_d   = WAIT_SOF;
        end else begin
          state_d = CAPTURE;
        end
      end else begin
        drop    = 1'b1;
        state_d = (wpf_eff == CNT_ONE) ? WAIT_SOF : DROP;
      end
    end
  end

  // Host-side frame accounting: a frame leaves frames_avail once need_q
  // words of it have been read.
  assign rd_eff = host_rd_i & ~empty;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    dec      = 1'b0;
    if (rd_eff) begin
      if (rd_cnt_q + NEED_ONE == need_q) begin
        rd_cnt_d = '0;
        dec      = 1'b1;
      end else begin
        rd_cnt_d = rd_cnt_q + NEED_ONE;
      end
    end
    avail_d = avail_q;
    if (frame_complete && !dec && !(&avail_q))   avail_d = avail_q + 1'b1;
    else if (dec && !frame_complete && |avail_q) avail_d = avail_q - 1'b1;
    err_d  = err_q | abandon | lost_word | (host_rd_i & empty);
    fcnt_d = fcnt_q + {15'd0, fcnt_inc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wpf_q    <= '0;
      need_q   <= '0;
      rd_cnt_q <= '0;
      avail_q  <= '0;
      fcnt_q   <= '0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wpf_q    <= wpf_d;
      need_q   <= need_d;
      rd_cnt_q <= rd_cnt_d;
      avail_q  <= avail_d;
      fcnt_q   <= fcnt_d;
      stall_q  <= int'(avail_q) >= STALL_FRAMES;
      err_q    <= err_d;
    end
  end

  assign frames_avail_o  = avail_q;
  assign stall_o         = stall_q;
  assign frame_done_o    = frame_complete;
  assign frame_dropped_o = drop;
  assign err_sticky_o    = err_q;
  assign frame_cnt_o     = fcnt_q;

endmodule
`default_nettype wire
